// File: rtl/biriscv_fetch_queue_pkg.sv
// Shared definitions for the fetch queue: entry layout, slot-mask encoding
// and the opcode substituted for faulting fetches.
package biriscv_fetch_queue_pkg;

  localparam int FQ_DATA_W  = 64 + 29 + 1;
  localparam int FQ_ENTRY_W = FQ_DATA_W + 2;

  localparam logic [1:0] MASK_NONE  = 2'b00;
  localparam logic [1:0] MASK_SLOT1 = 2'b10;
  localparam logic [1:0] MASK_BOTH  = 2'b11;

  localparam logic [31:0] FAULT_OPCODE = 32'h0;

  typedef struct packed {
    logic [63:0] instr;
    logic [28:0] pc;
    logic        fault;
  } fq_data_t;

  // Drop the oldest pending slot from a mask.
  function automatic logic [1:0] clear_oldest(input logic [1:0] mask);
    return mask[0] ? {mask[1], 1'b0} : MASK_NONE;
  endfunction

endpackage

// File: rtl/biriscv_fetch_queue.sv
// Instruction fetch queue: buffers fetch groups and presents up to two
// in-order instructions per cycle from the head entry.
module biriscv_fetch_queue
  import biriscv_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [63:0] fetch_instr_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_fault_i,
  output logic        fetch_accept_o,
  input  logic        flush_i,
  output logic        out0_valid_o,
  output logic [31:0] out0_instr_o,
  output logic [31:0] out0_pc_o,
  output logic        out0_fault_o,
  output logic        out1_valid_o,
  output logic [31:0] out1_instr_o,
  output logic [31:0] out1_pc_o,
  output logic        out1_fault_o,
  input  logic        out0_accept_i,
  input  logic        out1_accept_i
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  fq_data_t      data_q [DEPTH];
  logic [1:0]    mask_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;

  fq_data_t   head;
  logic [1:0] head_mask;
  logic       head_valid;
  logic       push, pop_pair, pop_one, retire;
  logic [1:0] next_mask;
  logic       unused_pc_lsb;

  assign unused_pc_lsb = ^fetch_pc_i[1:0];

  assign head       = data_q[rd_ptr_q];
  assign head_mask  = mask_q[rd_ptr_q];
  assign head_valid = (count_q != '0) && (head_mask != MASK_NONE);

  assign fetch_accept_o = (count_q != FULL);

  // Head-slot mux; outputs are zeroed when nothing is presented.
  assign out0_valid_o = head_valid;
  assign out0_fault_o = head_valid & head.fault;
  assign out0_instr_o = !head_valid ? 32'h0 :
                        head.fault  ? FAULT_OPCODE :
                        head_mask[0] ? head.instr[31:0] : head.instr[63:32];
  assign out0_pc_o    = head_valid ? {head.pc, ~head_mask[0], 2'b00} : 32'h0;

  assign out1_valid_o = head_valid && (head_mask == MASK_BOTH) && !head.fault;
  assign out1_instr_o = out1_valid_o ? head.instr[63:32] : 32'h0;
  assign out1_pc_o    = out1_valid_o ? {head.pc, 3'b100} : 32'h0;
  assign out1_fault_o = 1'b0;

  assign push      = fetch_valid_i & fetch_accept_o & ~flush_i;
  assign pop_pair  = out0_accept_i & out1_accept_i & out1_valid_o;
  assign pop_one   = out0_accept_i & out0_valid_o & ~pop_pair;
  assign next_mask = clear_oldest(head_mask);
  assign retire    = pop_pair | (pop_one && (next_mask == MASK_NONE));

  // Payload storage needs no reset: outputs are qualified by count and mask.
  always_ff @(posedge clk_i) begin
    if (push)
      data_q[wr_ptr_q] <= '{instr: fetch_instr_i, pc: fetch_pc_i[31:3],
                            fault: fetch_fault_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mask_q[i] <= MASK_NONE;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mask_q[i] <= MASK_NONE;
    end else begin
      if (retire) begin
        mask_q[rd_ptr_q] <= MASK_NONE;
        rd_ptr_q         <= rd_ptr_q + 1'b1;
      end else if (pop_one) begin
        mask_q[rd_ptr_q] <= next_mask;
      end
      // A push never targets the head while it is being consumed (count != 0
      // with wr == rd implies full, and full blocks push).
      if (push) begin
        mask_q[wr_ptr_q] <= {1'b1, ~fetch_pc_i[2]};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      case ({push, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Directed bench for the fetch queue with hand-computed expectations.
module tb_biriscv_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [63:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_fault;
  logic        fetch_accept;
  logic        flush;
  logic        out0_valid, out0_fault, out1_valid, out1_fault;
  logic [31:0] out0_instr, out0_pc, out1_instr, out1_pc;
  logic        out0_accept, out1_accept;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  biriscv_fetch_queue #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_valid_i(fetch_valid), .fetch_instr_i(fetch_instr),
    .fetch_pc_i(fetch_pc), .fetch_fault_i(fetch_fault),
    .fetch_accept_o(fetch_accept), .flush_i(flush),
    .out0_valid_o(out0_valid), .out0_instr_o(out0_instr),
    .out0_pc_o(out0_pc), .out0_fault_o(out0_fault),
    .out1_valid_o(out1_valid), .out1_instr_o(out1_instr),
    .out1_pc_o(out1_pc), .out1_fault_o(out1_fault),
    .out0_accept_i(out0_accept), .out1_accept_i(out1_accept)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 0; fetch_fault = 0; flush = 0;
    out0_accept = 0; out1_accept = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] s0,
                      input logic [31:0] s1, input logic flt);
    fetch_valid = 1; fetch_pc = pc; fetch_instr = {s1, s0}; fetch_fault = flt;
  endtask

  initial begin
    rst_n = 0; fetch_instr = '0; fetch_pc = '0;
    idle();
    repeat (2) step();
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_instr", out0_instr, 0);
    chk("rst_out0_pc",    out0_pc, 0);
    chk("rst_out0_fault", out0_fault, 0);
    chk("rst_out1_pc",    out1_pc, 0);
    chk("rst_accept",     fetch_accept, 1);
    rst_n = 1;
    step();

    // Dual-issue group at 0x1000; no bypass in the push cycle.
    push(32'h1000, 32'h00000013, 32'h00100093, 0);
    chk("t1_no_bypass", out0_valid, 0);
    step(); idle();
    chk("t1_out0_valid", out0_valid, 1);
    chk("t1_out0_instr", out0_instr, 32'h00000013);
    chk("t1_out0_pc",    out0_pc, 32'h1000);
    chk("t1_out1_valid", out1_valid, 1);
    chk("t1_out1_instr", out1_instr, 32'h00100093);
    chk("t1_out1_pc",    out1_pc, 32'h1004);
    chk("t1_hold_pc",    out0_pc, 32'h1000);
    out0_accept = 1; out1_accept = 1;
    step(); idle();
    chk("t1_empty0", out0_valid, 0);
    chk("t1_empty1", out1_valid, 0);

    // Group entering at slot1.
    push(32'h1004, 32'hDEADBEEF, 32'h00200113, 0);
    step(); idle();
    chk("t2_out0_valid", out0_valid, 1);
    chk("t2_out0_pc",    out0_pc, 32'h1004);
    chk("t2_out0_instr", out0_instr, 32'h00200113);
    chk("t2_out1_valid", out1_valid, 0);
    out0_accept = 1; out1_accept = 1;
    step(); idle();
    chk("t2_empty", out0_valid, 0);

    // Fill to DEPTH, hold off the fifth group, then drain in order.
    for (int k = 0; k < 4; k++) begin
      push(32'h3000 + 32'(8*k), 32'h100 + 32'(k), 32'h200 + 32'(k), 0);
      step();
    end
    chk("t3_full_accept", fetch_accept, 0);
    chk("t3_head_pc", out0_pc, 32'h3000);
    push(32'h3020, 32'h104, 32'h204, 0);
    out0_accept = 1; out1_accept = 1;
    step();
    out0_accept = 0; out1_accept = 0;
    chk("t3_accept_after_retire", fetch_accept, 1);
    chk("t3_head_pc2", out0_pc, 32'h3008);
    step(); idle();
    chk("t3_full_again", fetch_accept, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("t3_drain_pc",    out0_pc, 32'h3000 + 32'(8*k));
      chk("t3_drain_instr", out1_instr, 32'h200 + 32'(k));
      out0_accept = 1; out1_accept = 1;
      step();
    end
    idle();
    chk("t3_empty", out0_valid, 0);
    chk("t3_accept_empty", fetch_accept, 1);

    // Faulting group drains one slot per accept.
    push(32'h2000, 32'h11111111, 32'h22222222, 1);
    step(); idle();
    chk("t4_valid", out0_valid, 1);
    chk("t4_fault", out0_fault, 1);
    chk("t4_instr", out0_instr, 32'h0);
    chk("t4_pc",    out0_pc, 32'h2000);
    chk("t4_out1",  out1_valid, 0);
    out0_accept = 1; out1_accept = 1;
    step(); idle();
    chk("t4_pc2",    out0_pc, 32'h2004);
    chk("t4_fault2", out0_fault, 1);
    chk("t4_instr2", out0_instr, 32'h0);
    out1_accept = 1;
    step(); idle();
    chk("t4_lane1_only_ignored", out0_pc, 32'h2004);
    out0_accept = 1;
    step(); idle();
    chk("t4_empty", out0_valid, 0);

    // Flush with a concurrent push.
    for (int k = 0; k < 3; k++) begin
      push(32'h4000 + 32'(8*k), 32'h300 + 32'(k), 32'h400 + 32'(k), 0);
      step();
    end
    idle();
    push(32'h5000, 32'h555, 32'h556, 0);
    flush = 1; out0_accept = 1;
    step(); idle();
    chk("t5_out0_valid", out0_valid, 0);
    chk("t5_out1_valid", out1_valid, 0);
    chk("t5_accept",     fetch_accept, 1);
    step();
    chk("t5_never", out0_valid, 0);
    push(32'h6000, 32'h600, 32'h601, 0);
    step(); idle();
    chk("t5_post_flush_pc", out0_pc, 32'h6000);
    out0_accept = 1; out1_accept = 1;
    step(); idle();

    // Asynchronous reset with two entries queued.
    push(32'h7000, 32'h700, 32'h701, 0); step();
    push(32'h7008, 32'h708, 32'h709, 0); step();
    idle();
    chk("t6_pre_reset", out0_pc, 32'h7000);
    rst_n = 0;
    #1;
    chk("t6_async_valid", out0_valid, 0);
    chk("t6_async_pc",    out0_pc, 0);
    chk("t6_async_instr", out0_instr, 0);
    step();
    rst_n = 1;
    step();
    chk("t6_after_release", out0_valid, 0);
    push(32'h8000, 32'h800, 32'h801, 0);
    step(); idle();
    chk("t6_new_push", out0_pc, 32'h8000);
    chk("t6_new_out1", out1_instr, 32'h801);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
